// File: rtl/alu_arbiter.sv
// alu_64: combinational 64-bit ALU shared by the arbiter below.
//   out  : result of the selected operation
//   cc   : {negative, zero, signed overflow} of the result; overflow is only
//          meaningful for add/sub and reads 0 for the logic operations
//   mode : 0 add, 1 sub, 2 and, 3 xor
//   a, b : operands, treated as two's complement for overflow detection
//
// alu_arbiter: two-port round-robin front end for one shared alu_64.
//   clk, rst                    : clock, synchronous active-high reset
//   reqN_valid/ready            : request handshake per requester (N = 0, 1)
//   reqN_mode/a/b/setcc         : operation, operands, CC write enable
//   rsp_valid/ready             : one-entry response buffer handshake
//   rsp_id/out/cc               : owner, ALU result and ALU CC of the response
//   cc_q                        : architectural condition-code register
//   gnt_cnt0/gnt_cnt1           : wrapping per-requester grant counters
module alu_64 #(
  parameter int DW = 64
) (
  output logic [DW-1:0] out,
  output logic [2:0]    cc,
  input  logic [1:0]    mode,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b
);

  logic signed [DW-1:0] sa, sb, res;
  logic                 ovf;

  // Signed overflow: the operands agree in sign (after negating b for
  // subtraction) but the result sign differs.
  function automatic logic add_ovf(input logic sa_msb, input logic sb_msb,
                                   input logic res_msb);
    return (sa_msb == sb_msb) && (res_msb != sa_msb);
  endfunction

  always_comb begin
    sa  = a;
    sb  = b;
    res = '0;
    ovf = 1'b0;
    case (mode)
      2'd0: begin
        res = sa + sb;
        ovf = add_ovf(sa[DW-1], sb[DW-1], res[DW-1]);
      end
      2'd1: begin
        res = sa - sb;
        ovf = add_ovf(sa[DW-1], ~sb[DW-1], res[DW-1]);
      end
      2'd2:    res = sa & sb;
      default: res = sa ^ sb;
    endcase
  end

  assign out = res;
  assign cc  = {res[DW-1], (res == '0), ovf};

endmodule

module alu_arbiter #(
  parameter int DW   = 64,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [1:0]      req0_mode,
  input  logic [DW-1:0]   req0_a,
  input  logic [DW-1:0]   req0_b,
  input  logic            req0_setcc,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [1:0]      req1_mode,
  input  logic [DW-1:0]   req1_a,
  input  logic [DW-1:0]   req1_b,
  input  logic            req1_setcc,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic [DW-1:0]   rsp_out,
  output logic [2:0]      rsp_cc,
  output logic [2:0]      cc_q,
  output logic [CNTW-1:0] gnt_cnt0,
  output logic [CNTW-1:0] gnt_cnt1
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t            state, state_nxt;
  logic              last;
  logic              can_issue, gnt0, gnt1, gnt;
  logic [1:0]        alu_mode;
  logic [DW-1:0]     alu_a, alu_b, alu_out;
  logic [2:0]        alu_cc;
  logic              sel_setcc;
  logic              id_p1;
  logic [DW-1:0]     out_p1;
  logic [2:0]        cc_p1;
  logic [2:0]        ccq_p1;
  logic [CNTW-1:0]   cnt0_p1, cnt1_p1;

  // Stage 0: arbitration and shared ALU (combinational)
  // A full buffer can still accept when it is drained in the same cycle.
  // Readies are derived only from valids, state, rsp_ready and last, so the
  // two ports never depend on each other. last == 1 means requester 1 was
  // granted most recently, so requester 0 wins a tie.
  assign can_issue  = !rst && ((state == EMPTY) || rsp_ready);
  assign gnt0       = can_issue && req0_valid && (!req1_valid || last);
  assign gnt1       = can_issue && req1_valid && (!req0_valid || !last);
  assign gnt        = gnt0 || gnt1;
  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  // Requester 0 is the default path when nothing is granted.
  assign alu_mode  = gnt1 ? req1_mode  : req0_mode;
  assign alu_a     = gnt1 ? req1_a     : req0_a;
  assign alu_b     = gnt1 ? req1_b     : req0_b;
  assign sel_setcc = gnt1 ? req1_setcc : req0_setcc;

  alu_64 #(.DW(DW)) u_alu (
    .out  (alu_out),
    .cc   (alu_cc),
    .mode (alu_mode),
    .a    (alu_a),
    .b    (alu_b)
  );

  always_comb begin
    state_nxt = state;
    if (gnt)
      state_nxt = FULL;
    else if ((state == FULL) && rsp_ready)
      state_nxt = EMPTY;
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= EMPTY;
    else
      state <= state_nxt;
  end

  // Stage 1: response buffer, CC register and grant counters
  // Data registers only move on a grant; a drain without a grant just
  // clears the state and leaves the old values visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      last    <= 1'b1;
      id_p1   <= 1'b0;
      out_p1  <= '0;
      cc_p1   <= '0;
      ccq_p1  <= '0;
      cnt0_p1 <= '0;
      cnt1_p1 <= '0;
    end else if (gnt) begin
      last   <= gnt1;
      id_p1  <= gnt1;
      out_p1 <= alu_out;
      cc_p1  <= alu_cc;
      if (sel_setcc)
        ccq_p1 <= alu_cc;
      if (gnt1)
        cnt1_p1 <= cnt1_p1 + 1'b1;
      else
        cnt0_p1 <= cnt0_p1 + 1'b1;
    end
  end

  assign rsp_valid = (state == FULL);
  assign rsp_id    = id_p1;
  assign rsp_out   = out_p1;
  assign rsp_cc    = cc_p1;
  assign cc_q      = ccq_p1;
  assign gnt_cnt0  = cnt0_p1;
  assign gnt_cnt1  = cnt1_p1;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  localparam int DW   = 64;
  localparam int CNTW = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            req0_valid = 1'b0, req1_valid = 1'b0;
  logic            req0_ready, req1_ready;
  logic [1:0]      req0_mode = '0, req1_mode = '0;
  logic [DW-1:0]   req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic            req0_setcc = 1'b0, req1_setcc = 1'b0;
  logic            rsp_valid, rsp_ready = 1'b0, rsp_id;
  logic [DW-1:0]   rsp_out;
  logic [2:0]      rsp_cc, cc_q;
  logic [CNTW-1:0] gnt_cnt0, gnt_cnt1;

  int errors = 0;
  int checks = 0;

  alu_arbiter #(.DW(DW), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_mode(req0_mode),
    .req0_a(req0_a), .req0_b(req0_b), .req0_setcc(req0_setcc),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_mode(req1_mode),
    .req1_a(req1_a), .req1_b(req1_b), .req1_setcc(req1_setcc),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_out(rsp_out), .rsp_cc(rsp_cc), .cc_q(cc_q),
    .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
  );

  always #5 clk = ~clk;

  // Reference model state: the observable contents of the block.
  logic            m_valid = 1'b0, m_id = 1'b0, m_last = 1'b1;
  logic [DW-1:0]   m_out = '0;
  logic [2:0]      m_cc = '0, m_ccq = '0;
  logic [CNTW-1:0] m_cnt0 = '0, m_cnt1 = '0;

  // ALU from the arithmetic definition: exact signed result in DW+1 bits,
  // overflow when it does not fit in DW bits. CC = {neg, zero, ovf}.
  task automatic ref_alu(input logic [1:0] mode, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, output logic [DW-1:0] o,
                         output logic [2:0] c);
    logic [DW:0] wide;
    logic        v;
    v = 1'b0;
    o = '0;
    case (mode)
      2'd0: begin wide = {a[DW-1], a} + {b[DW-1], b}; o = wide[DW-1:0]; v = wide[DW] ^ wide[DW-1]; end
      2'd1: begin wide = {a[DW-1], a} - {b[DW-1], b}; o = wide[DW-1:0]; v = wide[DW] ^ wide[DW-1]; end
      2'd2: o = a & b;
      default: o = a ^ b;
    endcase
    c = {o[DW-1], (o == '0), v};
  endtask

  // Which requester the rules say is granted with the present inputs.
  function automatic int exp_grant();
    if (rst) return -1;
    if (m_valid && !rsp_ready) return -1;
    if (req0_valid && req1_valid) return m_last ? 0 : 1;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  // Advance one clock and apply the same step to the model.
  task automatic tick(output int g);
    logic [DW-1:0] o;
    logic [2:0]    c;
    logic          sc, r, rr;
    g = exp_grant();
    if (g == 1) ref_alu(req1_mode, req1_a, req1_b, o, c);
    else        ref_alu(req0_mode, req0_a, req0_b, o, c);
    sc = (g == 1) ? req1_setcc : req0_setcc;
    r  = rst;
    rr = rsp_ready;
    @(posedge clk);
    if (r) begin
      m_valid = 0; m_id = 0; m_last = 1; m_out = '0; m_cc = '0; m_ccq = '0;
      m_cnt0 = '0; m_cnt1 = '0;
    end else if (g >= 0) begin
      m_valid = 1; m_id = (g == 1); m_last = (g == 1); m_out = o; m_cc = c;
      if (sc) m_ccq = c;
      if (g == 1) m_cnt1 = m_cnt1 + 1'b1;
      else        m_cnt0 = m_cnt0 + 1'b1;
    end else if (m_valid && rr) begin
      m_valid = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    int g;
    @(negedge clk);
    rst = 1; req0_valid = 1; req1_valid = 1; rsp_ready = 1;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b want 00", {req0_ready, req1_ready}); end
    tick(g);
    tick(g);
    checks++; if ({rsp_valid, rsp_id, rsp_out, rsp_cc, cc_q, gnt_cnt0, gnt_cnt1} !== '0) begin
      errors++; $display("FAIL reset_state: valid=%b id=%b out=%h cc=%b ccq=%b c0=%0d c1=%0d want all 0",
                         rsp_valid, rsp_id, rsp_out, rsp_cc, cc_q, gnt_cnt0, gnt_cnt1);
    end
    @(negedge clk);
    rst = 0; req0_valid = 0; req1_valid = 0;
  endtask

  task automatic test_single();
    int g;
    @(negedge clk);
    req0_valid = 1; req0_mode = 0; req0_a = 54; req0_b = 46; req0_setcc = 1; rsp_ready = 1;
    #1;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b want 1", req0_ready); end
    tick(g);
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_out !== 64'd100) begin
      errors++; $display("FAIL single_rsp: valid=%b id=%b out=%0d want 1 0 100", rsp_valid, rsp_id, rsp_out);
    end
    checks++; if (rsp_cc !== 3'b000 || cc_q !== rsp_cc) begin
      errors++; $display("FAIL single_cc: cc=%b ccq=%b want 000 000", rsp_cc, cc_q);
    end
    @(negedge clk);
    req0_valid = 0; req0_setcc = 0;
  endtask

  task automatic test_round_robin();
    int g;
    @(negedge clk);
    rst = 1;
    tick(g);
    @(negedge clk);
    rst = 0; rsp_ready = 1;
    req0_valid = 1; req0_mode = 0; req0_a = 1000; req0_b = -64'sd15;
    req1_valid = 1; req1_mode = 1; req1_a = 54;   req1_b = 46;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checks++; if ({req1_ready, req0_ready} !== ((i % 2) ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL rr_ready[%0d]: got r1r0=%b%b want grant %0d", i, req1_ready, req0_ready, i % 2);
      end
      tick(g);
      checks++; if (rsp_id !== 1'(i % 2) || rsp_out !== ((i % 2) ? 64'd8 : 64'd985)) begin
        errors++; $display("FAIL rr_rsp[%0d]: id=%b out=%0d want %0d %0d", i, rsp_id, rsp_out, i % 2, (i % 2) ? 8 : 985);
      end
    end
    checks++; if (gnt_cnt0 !== 16'd2 || gnt_cnt1 !== 16'd2) begin
      errors++; $display("FAIL rr_cnt: c0=%0d c1=%0d want 2 2", gnt_cnt0, gnt_cnt1);
    end
  endtask

  task automatic test_backpressure();
    int g;
    logic [DW-1:0] s_out;
    logic [2:0]    s_cc;
    logic          s_id;
    s_out = rsp_out; s_cc = rsp_cc; s_id = rsp_id;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rsp_ready = 0;
      #1;
      checks++; if ({req0_ready, req1_ready} !== 2'b00) begin
        errors++; $display("FAIL bp_ready[%0d]: got %b%b want 00", i, req0_ready, req1_ready);
      end
      tick(g);
      checks++; if (rsp_valid !== 1'b1 || rsp_out !== s_out || rsp_cc !== s_cc || rsp_id !== s_id) begin
        errors++; $display("FAIL bp_hold[%0d]: valid=%b out=%0d id=%b want 1 %0d %b", i, rsp_valid, rsp_out, rsp_id, s_out, s_id);
      end
    end
    @(negedge clk);
    rsp_ready = 1;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++; $display("FAIL bp_release_ready: got r0r1=%b%b want 10", req0_ready, req1_ready);
    end
    tick(g);
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_out !== 64'd985) begin
      errors++; $display("FAIL bp_release_rsp: valid=%b id=%b out=%0d want 1 0 985", rsp_valid, rsp_id, rsp_out);
    end
  endtask

  task automatic test_setcc();
    int g;
    logic [2:0] s_ccq;
    @(negedge clk);
    s_ccq = cc_q;
    req0_valid = 0; rsp_ready = 1;
    req1_valid = 1; req1_mode = 2; req1_a = 64'hFF; req1_b = 64'h0F; req1_setcc = 0;
    tick(g);
    checks++; if (rsp_out !== 64'h0F || rsp_id !== 1'b1 || cc_q !== s_ccq) begin
      errors++; $display("FAIL setcc_off: out=%h id=%b ccq=%b want 0f 1 %b", rsp_out, rsp_id, cc_q, s_ccq);
    end
    @(negedge clk);
    req1_mode = 3; req1_a = 5; req1_b = 5; req1_setcc = 1;
    tick(g);
    checks++; if (rsp_out !== 64'd0 || cc_q !== 3'b010 || rsp_cc !== 3'b010) begin
      errors++; $display("FAIL setcc_on: out=%0d ccq=%b cc=%b want 0 010 010", rsp_out, cc_q, rsp_cc);
    end
    @(negedge clk);
    req1_valid = 0; req1_setcc = 0;
  endtask

  task automatic test_overflow();
    int g;
    @(negedge clk);
    req0_valid = 1; req0_mode = 0; req0_a = 64'd1 << 62; req0_b = 64'd1 << 62; req0_setcc = 0;
    tick(g);
    checks++; if (rsp_out !== 64'h8000_0000_0000_0000 || rsp_cc !== 3'b101 || rsp_cc !== m_cc) begin
      errors++; $display("FAIL overflow: out=%h cc=%b want 8000000000000000 101", rsp_out, rsp_cc);
    end
  endtask

  task automatic test_reset_mid();
    int g;
    @(negedge clk);
    rsp_ready = 0; rst = 1;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre: valid=%b want 1", rsp_valid); end
    tick(g);
    checks++; if (rsp_valid !== 1'b0 || cc_q !== 3'b000 || gnt_cnt0 !== '0 || gnt_cnt1 !== '0) begin
      errors++; $display("FAIL midrst_state: valid=%b ccq=%b c0=%0d c1=%0d want 0 000 0 0", rsp_valid, cc_q, gnt_cnt0, gnt_cnt1);
    end
    @(negedge clk);
    rst = 0; rsp_ready = 1; req0_valid = 1; req1_valid = 1;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++; $display("FAIL midrst_tie: got r0r1=%b%b want 10", req0_ready, req1_ready);
    end
    tick(g);
    checks++; if (rsp_id !== 1'b0 || rsp_valid !== 1'b1) begin
      errors++; $display("FAIL midrst_rsp: id=%b valid=%b want 0 1", rsp_id, rsp_valid);
    end
  endtask

  task automatic test_wrap();
    int g;
    @(negedge clk);
    rst = 1;
    tick(g);
    @(negedge clk);
    rst = 0; rsp_ready = 1; req0_valid = 1; req1_valid = 0;
    for (int i = 0; i < 65535; i++) tick(g);
    checks++; if (gnt_cnt0 !== 16'hFFFF) begin errors++; $display("FAIL wrap_max: c0=%0d want 65535", gnt_cnt0); end
    tick(g);
    checks++; if (gnt_cnt0 !== 16'd0 || gnt_cnt1 !== 16'd0) begin
      errors++; $display("FAIL wrap_zero: c0=%0d c1=%0d want 0 0", gnt_cnt0, gnt_cnt1);
    end
  endtask

  task automatic test_random();
    int   eg, g;
    logic pend0, pend1;
    pend0 = 0; pend1 = 0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (!pend0 && $urandom_range(2) != 0) begin
        pend0 = 1; req0_mode = 2'($urandom_range(3)); req0_setcc = 1'($urandom_range(1));
        req0_a = ($urandom_range(3) == 0) ? 64'h8000_0000_0000_0000 : {$urandom, $urandom};
        req0_b = ($urandom_range(3) == 0) ? 64'h7FFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
      end
      if (!pend1 && $urandom_range(2) != 0) begin
        pend1 = 1; req1_mode = 2'($urandom_range(3)); req1_setcc = 1'($urandom_range(1));
        req1_a = ($urandom_range(3) == 0) ? req1_b : {$urandom, $urandom};
        req1_b = {$urandom, $urandom};
      end
      req0_valid = pend0;
      req1_valid = pend1;
      rsp_ready  = ($urandom_range(3) != 0);
      rst        = ($urandom_range(63) == 0);
      #1;
      eg = exp_grant();
      checks++; if (req0_ready !== (eg == 0) || req1_ready !== (eg == 1)) begin
        errors++; $display("FAIL rnd_ready[%0d]: got r0r1=%b%b want grant %0d", i, req0_ready, req1_ready, eg);
      end
      tick(g);
      if (g == 0) pend0 = 0;
      if (g == 1) pend1 = 0;
      checks++; if (rsp_valid !== m_valid || rsp_id !== m_id || rsp_out !== m_out || rsp_cc !== m_cc) begin
        errors++; $display("FAIL rnd_rsp[%0d]: v=%b id=%b out=%h cc=%b want %b %b %h %b",
                           i, rsp_valid, rsp_id, rsp_out, rsp_cc, m_valid, m_id, m_out, m_cc);
      end
      checks++; if (cc_q !== m_ccq || gnt_cnt0 !== m_cnt0 || gnt_cnt1 !== m_cnt1) begin
        errors++; $display("FAIL rnd_state[%0d]: ccq=%b c0=%0d c1=%0d want %b %0d %0d",
                           i, cc_q, gnt_cnt0, gnt_cnt1, m_ccq, m_cnt0, m_cnt1);
      end
    end
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_setcc();
    test_overflow();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port arbiter and sequencer that shares a single `alu_64` instance (port order out, CC, mode, a, b) between two requesters, e.g. the execute stage and the address-calculation path. Each request carries mode and two 64-bit operands. The block grants one request per cycle using round-robin, registers the ALU result and condition codes into a one-entry response buffer with a valid/ready handshake, and optionally latches the condition codes into an architectural CC register. It also keeps per-requester grant counters for performance monitoring.

## Interface
- `DW`, 64, operand/result width; must match `alu_64`.
- `CNTW`, 16, width of each grant counter.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `req0_valid`  in  1  requester 0 has an operation.
- `req0_ready`  out  1  requester 0 granted this cycle.
- `req0_mode`  in  2  0 add, 1 sub, 2 and, 3 xor (alu_64 encoding).
- `req0_a`, `req0_b`  in  DW  operands.
- `req0_setcc`  in  1  on grant, write ALU CC into `cc_q`.
- `req1_valid`, `req1_ready`, `req1_mode`, `req1_a`, `req1_b`, `req1_setcc`: same as requester 0.
- `rsp_valid`  out  1  response buffer full.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_id`  out  1  requester that owns the response.
- `rsp_out`  out  DW  ALU result.
- `rsp_cc`  out  3  ALU CC, bit-for-bit as `alu_64` drives it.
- `cc_q`  out  3  architectural condition-code register.
- `gnt_cnt0`, `gnt_cnt1`  out  CNTW  grant counters.

## Operation
- States: EMPTY (`rsp_valid`=0) and FULL (`rsp_valid`=1).
- `can_issue` = EMPTY, or FULL && `rsp_ready`. Issue while draining gives full throughput.
- Arbitration when `can_issue`:
  - Only one requester valid: grant it.
  - Both valid: grant the requester that was not granted last, tracked by the `last` pointer.
  - No requester valid: no grant.
- `reqN_ready` is combinational from the valids, state, `rsp_ready` and `last`. It never depends on `reqN_ready` of the other port. At most one ready is high per cycle.
- ALU input mux selects the granted requester's mode/a/b. When there is no grant, it selects requester 0; the output is don't-care.
- On a grant edge:
  - Capture `rsp_out`, `rsp_cc` and `rsp_id` from that requester's operation; `rsp_valid` goes to 1.
  - `last` becomes the granted id.
  - The granted counter increments and wraps modulo 2^CNTW.
  - If that requester's `setcc`=1, `cc_q` takes the ALU CC; otherwise `cc_q` holds.
- When FULL && `rsp_ready` && no grant: go to EMPTY. Data registers hold their old values.
- When FULL && !`rsp_ready`: all `rsp_*` outputs hold stable and both readies are 0.
- Requesters must hold valid, mode, operands and setcc stable until ready. A valid may drop only after its handshake.
- Arithmetic, including overflow and sign, is entirely `alu_64`'s. The block adds no width extension or truncation.

## Timing
- Reset values:
  - `rsp_valid`=0, `rsp_id`=0, `rsp_out`=0, `rsp_cc`=0, `cc_q`=0.
  - `gnt_cnt0`=`gnt_cnt1`=0.
  - `last`=1, so requester 0 wins the first tie.
- While `rst`=1, both readies are 0.
- Latency: a grant at edge N puts the response on `rsp_*` and updates `cc_q` visibly after edge N.
- Throughput: one operation per cycle when `rsp_ready`=1 continuously.
- Reset asserted while FULL discards the held response. No handshake completes in the reset cycle.
- Simultaneous drain and grant: the buffer stays FULL with the new data; no bubble.
- Both grant counters may wrap independently: 2^CNTW−1 followed by a grant gives 0.

## Test plan
- Single request: requester 0, mode 0, a=54, b=46, setcc=1, rsp_ready=1.
  - `req0_ready`=1 in the request cycle.
  - Next cycle: `rsp_valid`=1, `rsp_id`=0, `rsp_out`=100, `rsp_cc` equals the `alu_64` CC for 54+46, and `cc_q`=`rsp_cc`.
- Round-robin: both valid every cycle with requester 0 add(1000,−15), requester 1 sub(54,46), rsp_ready=1.
  - Grants alternate 0,1,0,1 starting with 0.
  - `rsp_out` alternates 985, 8.
  - After 4 grants: `gnt_cnt0`=2, `gnt_cnt1`=2.
- Backpressure: after a response, hold rsp_ready=0 for 3 cycles with both requesters valid.
  - Both readies are 0 and `rsp_*` is unchanged in all 3 cycles.
  - When rsp_ready=1, a new grant and the drain happen in the same cycle, with no empty cycle.
- setcc gating: requester 1 and(0xFF,0x0F) with setcc=0, then xor(5,5) with setcc=1.
  - `cc_q` is unchanged after the first operation.
  - After the second, `cc_q` equals the `alu_64` CC for result 0 and `rsp_out`=0.
- Overflow passthrough: requester 0 add(1<<62, 1<<62).
  - `rsp_out`=0x8000_0000_0000_0000 and `rsp_cc` equals the `alu_64` CC bit-for-bit.
- Reset mid-operation: rst=1 for one cycle while FULL.
  - Next cycle: `rsp_valid`=0, `cc_q`=0, both counters 0.
  - The first tie afterwards is granted to requester 0.
